aes_engine_ctrl: RTL and testbench

Sequencing controller for the AES streaming engine inside the HWPE. It takes a job (block count, mode) from the register-file trigger, starts the source and sink streamers, and enables and clears the engine. It counts 128-bit block handshakes on the engine input and output streams, gates input once the job is fully fetched, and raises a one-cycle done event for the event unit.

---
 rtl/aes_package.sv | 21 ++
 rtl/aes_blk_counter.sv | 42 ++++
 rtl/aes_engine_ctrl.sv | 145 ++++++++++++++
 tb/tb_aes_engine_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_package.sv
// Shared types and widths for the AES streaming engine controller.
package aes_package;

    localparam int AES_CNT_W  = 16;
    localparam int AES_MODE_W = 2;

    typedef struct packed {
        logic                  enable;
        logic                  clear;
        logic [AES_MODE_W-1:0] mode;
    } ctrl_engine_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_RUN       = 3'd2,
        ST_WAIT_SINK = 3'd3,
        ST_DONE      = 3'd4
    } aes_ctrl_state_e;

endpackage

// File: rtl/aes_blk_counter.sv
// Saturating block counter: stops at limit_i, flags the increment that reaches it.
module aes_blk_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             at_limit_o,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc    = cnt_q + 1'b1;
    assign at_limit_o = (cnt_q >= limit_i);
    // hit_o marks the handshake that makes the count equal the limit
    assign hit_o      = en_i & ~clear_i & ~at_limit_o & (cnt_inc == limit_i);
    assign cnt_o      = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !at_limit_o) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes_engine_ctrl.sv
// Job sequencer for the AES streaming engine: starts streamers, counts blocks,
// gates input once fetched and signals completion.
module aes_engine_ctrl
    import aes_package::*;
#(
    parameter int CNT_W  = AES_CNT_W,
    parameter int MODE_W = AES_MODE_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              test_mode_i,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  cfg_len_i,
    input  logic [MODE_W-1:0] cfg_mode_i,
    input  logic              in_valid_i,
    input  logic              in_ready_i,
    input  logic              out_valid_i,
    input  logic              out_ready_i,
    input  logic              sink_done_i,
    output logic              src_start_o,
    output logic              sink_start_o,
    output logic              in_gate_o,
    output ctrl_engine_t      ctrl_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  blk_cnt_o
);

    aes_ctrl_state_e   state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              err_q, err_d;

    logic              in_hs, out_hs;
    logic              accept, cnt_clr;
    logic              in_full, in_last;
    logic              out_full, out_last;
    logic              is_run, in_gate;
    logic [CNT_W-1:0]  in_cnt, out_cnt;
    logic              unused_sigs;

    assign in_hs   = in_valid_i & in_ready_i;
    assign out_hs  = out_valid_i & out_ready_i;
    assign is_run  = (state_q == ST_RUN);
    assign in_gate = is_run & ~in_full;
    assign accept  = (state_q == ST_IDLE) & start_i & (cfg_len_i != '0);
    assign cnt_clr = clear_i | accept;

    aes_blk_counter #(.CNT_W(CNT_W)) u_in_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (cnt_clr),
        .en_i       (in_hs & in_gate),
        .limit_i    (len_q),
        .cnt_o      (in_cnt),
        .at_limit_o (in_full),
        .hit_o      (in_last)
    );

    aes_blk_counter #(.CNT_W(CNT_W)) u_out_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (cnt_clr),
        .en_i       (out_hs & is_run),
        .limit_i    (len_q),
        .cnt_o      (out_cnt),
        .at_limit_o (out_full),
        .hit_o      (out_last)
    );

    assign unused_sigs = ^{test_mode_i, in_cnt, in_last, out_full};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        mode_d  = mode_q;
        err_d   = err_q;

        if (start_i && busy_o)            err_d = 1'b1;
        if (in_hs && !in_gate)            err_d = 1'b1;
        if (out_hs && !is_run)            err_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (cfg_len_i != '0) begin
                        len_d   = cfg_len_i;
                        mode_d  = cfg_mode_i;
                        err_d   = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_START:     state_d = ST_RUN;
            ST_RUN: begin
                if (out_last) state_d = sink_done_i ? ST_DONE : ST_WAIT_SINK;
            end
            ST_WAIT_SINK: begin
                if (sink_done_i) state_d = ST_DONE;
            end
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        // Soft clear aborts the job silently, overriding every transition
        if (clear_i) begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            mode_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.enable = is_run;
        ctrl_o.clear  = (state_q == ST_START);
        ctrl_o.mode   = mode_q;
    end

    assign src_start_o  = (state_q == ST_START);
    assign sink_start_o = (state_q == ST_START);
    assign in_gate_o    = in_gate;
    assign busy_o       = (state_q == ST_START) | is_run | (state_q == ST_WAIT_SINK);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = err_q;
    assign blk_cnt_o    = out_cnt;

endmodule

// File: tb/tb_aes_engine_ctrl.sv
// Directed bench for aes_engine_ctrl with a job-level reference model.
module tb_aes_engine_ctrl;
    import aes_package::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        test_mode = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_len = '0;
    logic [1:0]  cfg_mode = '0;
    logic        in_valid = 1'b0, in_ready = 1'b0;
    logic        out_valid = 1'b0, out_ready = 1'b0;
    logic        sink_done = 1'b0;

    logic         src_start_o, sink_start_o, in_gate_o, busy_o, done_o, err_o;
    ctrl_engine_t ctrl_o;
    logic [15:0]  blk_cnt_o;

    aes_engine_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .test_mode_i  (test_mode),
        .clear_i      (clear),
        .start_i      (start),
        .cfg_len_i    (cfg_len),
        .cfg_mode_i   (cfg_mode),
        .in_valid_i   (in_valid),
        .in_ready_i   (in_ready),
        .out_valid_i  (out_valid),
        .out_ready_i  (out_ready),
        .sink_done_i  (sink_done),
        .src_start_o  (src_start_o),
        .sink_start_o (sink_start_o),
        .in_gate_o    (in_gate_o),
        .ctrl_o       (ctrl_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .blk_cnt_o    (blk_cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;

    // Job-level model: a pending-start flag, an active-job flag, a drained flag
    // (all outputs delivered), a pending-done flag and the block tallies.
    bit m_startp, m_job, m_drained, m_donep, m_err;
    int m_ins, m_outs, m_len, m_mode;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic check_all();
        bit e_busy, e_en, e_gate;
        e_busy = m_startp | m_job;
        e_en   = m_job & !m_drained;
        e_gate = e_en && (m_ins < m_len);
        chk("src_start", src_start_o, m_startp);
        chk("sink_start", sink_start_o, m_startp);
        chk("in_gate", in_gate_o, e_gate);
        chk("ctrl", ctrl_o, {e_en, m_startp, m_mode[1:0]});
        chk("busy", busy_o, e_busy);
        chk("done", done_o, m_donep);
        chk("err", err_o, m_err);
        chk("blk_cnt", blk_cnt_o, m_outs);
    endtask

    task automatic idle_in();
        clear = 0; start = 0; in_valid = 0; in_ready = 0;
        out_valid = 0; out_ready = 0; sink_done = 0;
    endtask

    task automatic cyc();
        bit e_busy, e_en, e_gate, ihs, ohs, was_startp, was_donep;
        e_busy = m_startp | m_job;
        e_en   = m_job & !m_drained;
        e_gate = e_en && (m_ins < m_len);
        ihs = in_valid & in_ready;
        ohs = out_valid & out_ready;
        if (clear) begin
            m_startp = 0; m_job = 0; m_donep = 0; m_drained = 0;
            m_ins = 0; m_outs = 0; m_err = 0;
        end else begin
            if (start && e_busy) m_err = 1;
            if (ihs && !e_gate)  m_err = 1;
            if (ohs && !e_en)    m_err = 1;
            was_startp = m_startp;
            was_donep  = m_donep;
            m_donep = 0;
            if (was_startp) begin
                m_startp = 0;
                m_job = 1;
            end else if (m_job) begin
                if (!m_drained) begin
                    if (ihs && e_gate) m_ins++;
                    if (ohs) begin
                        m_outs++;
                        if (m_outs == m_len) m_drained = 1;
                    end
                    if (m_drained && sink_done) begin m_job = 0; m_donep = 1; end
                end else if (sink_done) begin
                    m_job = 0; m_donep = 1;
                end
            end else if (!was_donep && start) begin
                if (cfg_len != 0) begin
                    m_len = int'(cfg_len); m_mode = int'(cfg_mode);
                    m_err = 0; m_startp = 1; m_drained = 0;
                    m_ins = 0; m_outs = 0;
                end else begin
                    m_donep = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (done_o === 1'b1) done_seen++;
        check_all();
    endtask

    task automatic do_reset();
        rst_ni = 0;
        #1;
        m_startp = 0; m_job = 0; m_drained = 0; m_donep = 0; m_err = 0;
        m_ins = 0; m_outs = 0; m_len = 0; m_mode = 0;
        chk("rst_src_start", src_start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ctrl", ctrl_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_blk", blk_cnt_o, 0);
        chk("rst_gate", in_gate_o, 0);
        @(posedge clk);
        #1;
        rst_ni = 1;
        check_all();
    endtask

    task automatic run_job(input int len, input int mode, input int period, input int sink_delay,
                           input bit simul, input bit inj_start, input bit extra_out,
                           input int clr_at, input bit exp_err);
        int d0, ins_s, outs_s, k;
        bit ih, oh;
        d0 = done_seen;
        idle_in();
        start = 1; cfg_len = 16'(len); cfg_mode = 2'(mode);
        cyc();
        chk("src_start_c1", src_start_o, 1);
        chk("sink_start_c1", sink_start_o, 1);
        start = 0;
        cyc();
        ins_s = 0; outs_s = 0; k = 0;
        while (outs_s < len && k < 200) begin
            idle_in();
            if (clr_at != 0 && outs_s == clr_at) begin
                clear = 1;
                cyc();
                break;
            end
            in_valid  = (ins_s < len);
            in_ready  = 1;
            out_valid = (outs_s < ins_s);
            out_ready = ((k % period) == 0);
            if (inj_start && k == 3) start = 1;
            ih = in_valid && in_ready;
            oh = out_valid && out_ready;
            if (simul && oh && outs_s + 1 == len) sink_done = 1;
            cyc();
            if (ih) begin
                ins_s++;
                if (ins_s == len) chk("gate_drop", in_gate_o, 0);
            end
            if (oh) outs_s++;
            k++;
        end
        idle_in();
        if (clr_at != 0) begin
            chk("clr_idle_busy", busy_o, 0);
            chk("clr_blk", blk_cnt_o, 0);
            cyc(); cyc(); cyc();
            chk("clr_no_done", done_seen - d0, 0);
            return;
        end
        if (!simul) begin
            for (int i = 1; i < sink_delay; i++) begin
                idle_in();
                if (extra_out && i == 1) begin out_valid = 1; out_ready = 1; end
                cyc();
            end
            idle_in();
            sink_done = 1;
            cyc();
        end
        idle_in();
        cyc(); cyc(); cyc();
        chk("done_once", done_seen - d0, 1);
        chk("blk_hold", blk_cnt_o, len);
        chk("err_end", err_o, exp_err);
    endtask

    initial begin
        do_reset();
        repeat (2) cyc();

        // basic job, len=4, full rate, sink_done two cycles after last output
        run_job(4, 2, 1, 2, 0, 0, 0, 0, 0);

        // zero length job
        begin
            int d0;
            d0 = done_seen;
            idle_in(); start = 1; cfg_len = 0; cfg_mode = 1;
            cyc();
            chk("zl_done_c1", done_o, 1);
            chk("zl_no_src", src_start_o, 0);
            chk("zl_busy", busy_o, 0);
            idle_in();
            cyc(); cyc();
            chk("zl_done_once", done_seen - d0, 1);
        end

        // backpressure: out_ready one cycle in three
        run_job(3, 1, 3, 2, 0, 0, 0, 0, 0);
        // start while busy
        run_job(5, 0, 1, 2, 0, 1, 0, 0, 1);
        // extra output handshake in WAIT_SINK
        run_job(3, 1, 1, 3, 0, 0, 1, 0, 1);
        // soft clear after three outputs
        run_job(8, 2, 1, 2, 0, 0, 0, 3, 0);

        // asynchronous reset mid-job
        idle_in(); start = 1; cfg_len = 8; cfg_mode = 3;
        cyc();
        idle_in(); cyc();
        in_valid = 1; in_ready = 1;
        cyc(); cyc();
        idle_in();
        do_reset();
        repeat (3) cyc();
        chk("rst_no_done", done_o, 0);

        // last output together with sink_done
        run_job(2, 3, 1, 0, 1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
